// File: rtl/seg_scan_driver_pkg.sv
// Shared types and constants for the seg_scan_driver slice: FSM encoding,
// value limits and the display slot-to-digit ordering.
package seg_scan_driver_pkg;

  localparam int unsigned DIN_W    = 14;
  localparam int unsigned BCD_W    = 16;
  localparam int unsigned MAX_DISP = 9999;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  // Value is the nibble index of the digit inside the packed BCD word
  typedef enum logic [1:0] {
    DIG_UNITS     = 2'd0,
    DIG_TENS      = 2'd1,
    DIG_HUNDREDS  = 2'd2,
    DIG_THOUSANDS = 2'd3
  } digit_t;

  function automatic digit_t slot_digit(input logic [1:0] slot);
    case (slot)
      2'd0:    return DIG_THOUSANDS;
      2'd1:    return DIG_HUNDREDS;
      2'd2:    return DIG_TENS;
      default: return DIG_UNITS;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Value/strobe input and scan/status output bundle of seg_scan_driver.
interface seg_scan_driver_if;
  import seg_scan_driver_pkg::*;

  logic [DIN_W-1:0] din;
  logic             din_vld;
  logic             busy;
  logic             upd_done;
  logic [1:0]       sel;
  logic [3:0]       key;

  modport master (output din, din_vld, input busy, upd_done, sel, key);
  modport slave  (input din, din_vld, output busy, upd_done, sel, key);
endinterface

// File: rtl/seg_scan_driver_bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per clock,
// DIN_W iterations per conversion, start/busy/done handshake.
module bin2bcd_seq
  import seg_scan_driver_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic [DIN_W-1:0] sh_q;
  logic [BCD_W-1:0] acc_q;
  logic [BCD_W-1:0] acc_adj;
  logic [3:0]       cnt_q;
  logic             run_q;
  logic             done_q;

  always_comb begin
    acc_adj = acc_q;
    for (int unsigned i = 0; i < BCD_W / 4; i++) begin
      if (acc_q[i*4 +: 4] >= 4'd5) acc_adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start && !run_q) begin
        sh_q  <= bin;
        acc_q <= '0;
        cnt_q <= '0;
        run_q <= 1'b1;
      end else if (run_q) begin
        {acc_q, sh_q} <= {acc_adj[BCD_W-2:0], sh_q, 1'b0};
        cnt_q         <= cnt_q + 4'd1;
        if (cnt_q == 4'(DIN_W - 1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy = run_q;
  assign done = done_q;
  assign bcd  = acc_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Binary-to-4-digit BCD display driver with free-running digit scan.
// Optional macro OVERRANGE_CLAMP_EN: clamp din>9999 to 9999 instead of ignoring it.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 12000
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_driver_if.slave  bus
);

  state_t           state_q, state_d;
  logic             accept;
  logic             in_range;
  logic [DIN_W-1:0] conv_in;
  logic             conv_start;
  logic             load_en;
  logic             cv_busy;
  logic             cv_done;
  logic [BCD_W-1:0] cv_bcd;
  logic [BCD_W-1:0] disp_q;
  logic             busy_q;
  logic             upd_q;
  logic [15:0]      pre_q;
  logic [1:0]       sel_q;

`ifdef OVERRANGE_CLAMP_EN
  assign in_range = 1'b1;
  assign conv_in  = (bus.din > DIN_W'(MAX_DISP)) ? DIN_W'(MAX_DISP) : bus.din;
`else
  assign in_range = (bus.din <= DIN_W'(MAX_DISP));
  assign conv_in  = bus.din;
`endif

  assign accept = bus.din_vld && (state_q == ST_IDLE) && in_range && !cv_busy;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .bin   (conv_in),
    .busy  (cv_busy),
    .done  (cv_done),
    .bcd   (cv_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)  state_d = ST_CONV;
      ST_CONV: if (cv_done) state_d = ST_LOAD;
      ST_LOAD:              state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    conv_start = accept;
    load_en    = (state_q == ST_LOAD);
  end

  // busy lags the CONV state by one clock so it spans the LOAD cycle as well
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      upd_q  <= 1'b0;
      disp_q <= '0;
    end else begin
      busy_q <= (state_q == ST_CONV);
      upd_q  <= load_en;
      if (load_en) disp_q <= cv_bcd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      sel_q <= '0;
    end else if (pre_q == 16'(SCAN_DIV - 1)) begin
      pre_q <= '0;
      sel_q <= sel_q + 2'd1;
    end else begin
      pre_q <= pre_q + 16'd1;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.upd_done = upd_q;
  assign bus.sel      = sel_q;
  assign bus.key      = disp_q[{slot_digit(sel_q), 2'b00} +: 4];

endmodule
